// File: rtl/rng_sample_reader.sv
// rng_sample_reader: gates the TRNG, discards warm-up, runs RCT/APT health tests
// and buffers passing bytes in a small FIFO with a valid/ready output.
module rng_sample_reader #(
  parameter int WARMUP     = 16,
  parameter int RCT_CUTOFF = 8,
  parameter int APT_WINDOW = 64,
  parameter int APT_CUTOFF = 40,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] sample_in,
  output logic       rng_enable,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       rct_fail,
  output logic       apt_fail,
  output logic [7:0] drop_count
);
  localparam int WW = $clog2(WARMUP + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_ALARM} state_e;
  state_e state_q, state_d;
  logic [WW-1:0] wu_q;
  logic [7:0] prev_q, rct_q, rct_d, apt_ref_q, drop_q;
  logic [8:0] apt_cnt_q, apt_cnt_d, apt_pos_q, apt_pos_d;
  logic rct_fail_q, apt_fail_q;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0] cnt_q;
  logic active, arm, clr, new_win, rct_hit, apt_hit, fail, full, pop, push, wr_en, drop;
  // A zero RCT count or zero APT position marks the first sample after re-arm.
  always_comb begin
    active = state_q == S_WARMUP || state_q == S_RUN;
    arm = state_q == S_IDLE && start;
    clr = state_q == S_ALARM && clear;
    rct_d = (rct_q != 8'd0 && sample_in == prev_q) ? rct_q + 8'd1 : 8'd1;
    new_win = apt_pos_q == 9'd0 || apt_pos_q == 9'(APT_WINDOW);
    apt_cnt_d = new_win ? 9'd1 : apt_cnt_q + 9'(sample_in == apt_ref_q);
    apt_pos_d = new_win ? 9'd1 : apt_pos_q + 9'd1;
    rct_hit = active && rct_d == 8'(RCT_CUTOFF);
    apt_hit = active && apt_cnt_d == 9'(APT_CUTOFF);
    fail = rct_hit || apt_hit;
    full = cnt_q == (AW+1)'(FIFO_DEPTH);
    pop = out_valid && out_ready;
    push = state_q == S_RUN && !fail;
    wr_en = push && (!full || pop);
    drop = push && full && !pop;
    state_d = arm ? S_WARMUP : clr ? S_IDLE : fail ? S_ALARM :
              (state_q == S_WARMUP && wu_q == WW'(WARMUP - 1)) ? S_RUN : state_q;
  end
  assign rng_enable = active;
  assign out_valid = cnt_q != '0;
  assign out_data = out_valid ? mem_q[rd_q] : 8'd0;
  assign rct_fail = rct_fail_q;
  assign apt_fail = apt_fail_q;
  assign drop_count = drop_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      wu_q <= '0;
      prev_q <= '0;
      rct_q <= '0;
      apt_ref_q <= '0;
      apt_cnt_q <= '0;
      apt_pos_q <= '0;
      rct_fail_q <= 1'b0;
      apt_fail_q <= 1'b0;
      drop_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        wu_q <= '0;
        rct_q <= '0;
        apt_cnt_q <= '0;
        apt_pos_q <= '0;
      end else if (active) begin
        prev_q <= sample_in;
        rct_q <= rct_d;
        apt_cnt_q <= apt_cnt_d;
        apt_pos_q <= apt_pos_d;
        if (new_win) apt_ref_q <= sample_in;
        if (state_q == S_WARMUP) wu_q <= wu_q + WW'(1);
      end
      rct_fail_q <= clr ? 1'b0 : rct_fail_q | rct_hit;
      apt_fail_q <= clr ? 1'b0 : apt_fail_q | apt_hit;
      drop_q <= clr ? 8'd0 : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      if (fail) begin
        rd_q <= '0;
        wr_q <= '0;
        cnt_q <= '0;
      end else begin
        if (wr_en) wr_q <= wr_q + AW'(1);
        if (pop) rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clk) if (wr_en) mem_q[wr_q] <= sample_in;
endmodule

// File: tb/tb_rng_sample_reader.sv
// tb_rng_sample_reader: directed vectors with hand-computed expectations.
module tb_rng_sample_reader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [7:0] sample_in = 8'd0;
  logic rng_enable, out_valid, rct_fail, apt_fail;
  logic [7:0] out_data, drop_count;
  logic [7:0] v;
  int total = 0, bad = 0;
  rng_sample_reader dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .sample_in(sample_in),
    .rng_enable(rng_enable), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .rct_fail(rct_fail), .apt_fail(apt_fail), .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [7:0] base);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sample_in = base + 8'(i);
      tick;
    end
  endtask
  initial begin
    tick;
    tick;
    reset = 1'b0;
    chk("rst_en", rng_enable, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_rct", rct_fail, 0);
    chk("rst_apt", apt_fail, 0);
    chk("rst_drop", drop_count, 0);
    out_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_en", rng_enable, 1);
    for (int i = 0; i < 16; i++) begin
      sample_in = 8'(i);
      tick;
    end
    chk("warm_valid", out_valid, 0);
    for (int i = 16; i <= 30; i++) begin
      sample_in = 8'(i);
      tick;
      chk("run_valid", out_valid, 1);
      chk("run_data", out_data, i);
    end
    chk("run_rct", rct_fail, 0);
    chk("run_apt", apt_fail, 0);
    sample_in = 8'h5A;
    for (int k = 1; k <= 7; k++) tick;
    chk("rct7_flag", rct_fail, 0);
    chk("rct7_data", out_data, 8'h5A);
    tick;
    chk("rct8_flag", rct_fail, 1);
    chk("rct8_apt", apt_fail, 0);
    chk("rct8_en", rng_enable, 0);
    chk("rct8_valid", out_valid, 0);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("clr_rct", rct_fail, 0);
    chk("clr_en", rng_enable, 0);
    chk("clr_drop", drop_count, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int g = 1; g <= 20; g++) begin
      sample_in = 8'h33;
      tick;
      sample_in = 8'h33;
      if (g == 20) chk("apt_pre", apt_fail, 0);
      tick;
      if (g < 20) begin
        sample_in = 8'(g);
        tick;
      end
    end
    chk("apt_flag", apt_fail, 1);
    chk("apt_rct", rct_fail, 0);
    chk("apt_en", rng_enable, 0);
    chk("apt_valid", out_valid, 0);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    chk("apt_clr", apt_fail, 0);
    out_ready = 1'b0;
    go(8'h80);
    v = 8'h90;
    for (int k = 0; k < 4; k++) begin
      sample_in = v;
      v++;
      tick;
    end
    chk("full_valid", out_valid, 1);
    chk("full_data", out_data, 8'h90);
    chk("full_drop", drop_count, 0);
    sample_in = v;
    v++;
    tick;
    chk("drop1", drop_count, 1);
    sample_in = v;
    v++;
    tick;
    chk("drop2", drop_count, 2);
    out_ready = 1'b1;
    sample_in = v;
    v++;
    tick;
    out_ready = 1'b0;
    chk("pushpop_drop", drop_count, 2);
    chk("pushpop_data", out_data, 8'h91);
    for (int k = 0; k < 258; k++) begin
      sample_in = v;
      v++;
      tick;
    end
    chk("drop_sat", drop_count, 255);
    chk("hold_data", out_data, 8'h91);
    clear = 1'b1;
    sample_in = v;
    v++;
    tick;
    clear = 1'b0;
    chk("runclr_en", rng_enable, 1);
    chk("runclr_drop", drop_count, 255);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_en", rng_enable, 0);
    chk("midrst_drop", drop_count, 0);
    go(8'h10);
    for (int k = 0; k < 3; k++) begin
      sample_in = 8'hA0 + 8'(k);
      tick;
    end
    chk("three_valid", out_valid, 1);
    chk("three_data", out_data, 8'hA0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("rst3_valid", out_valid, 0);
    chk("rst3_en", rng_enable, 0);
    chk("rst3_data", out_data, 0);
    tick;
    chk("idle_en", rng_enable, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
